core_scheduler: RTL and testbench

//  Per-core control FSM. Drives core_state, which the fetcher, decoder, ALUs, LSUs and
//  PC units all qualify on (decoder latches in DECODE). Single PC shared by all enabled

---
 rtl/gpu_pkg.sv | 27 ++
 rtl/core_scheduler_if.sv | 30 +++
 rtl/core_scheduler.sv | 107 ++++++++++
 tb/tb_core_scheduler.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared GPU encodings: core FSM states, fetcher and LSU state codes, default widths.
package gpu_pkg;

  localparam int THREADS_DEF = 4;
  localparam int PC_BITS_DEF = 8;

  typedef enum logic [2:0] {
    CS_IDLE    = 3'd0,
    CS_FETCH   = 3'd1,
    CS_DECODE  = 3'd2,
    CS_REQUEST = 3'd3,
    CS_WAIT    = 3'd4,
    CS_EXECUTE = 3'd5,
    CS_UPDATE  = 3'd6,
    CS_DONE    = 3'd7
  } core_state_e;

  localparam logic [1:0] FETCHER_IDLE     = 2'd0;
  localparam logic [1:0] FETCHER_FETCHING = 2'd1;
  localparam logic [1:0] FETCHER_FETCHED  = 2'd2;

  localparam logic [1:0] LSU_IDLE       = 2'd0;
  localparam logic [1:0] LSU_REQUESTING = 2'd1;
  localparam logic [1:0] LSU_WAITING    = 2'd2;
  localparam logic [1:0] LSU_DONE       = 2'd3;

endpackage

// File: rtl/core_scheduler_if.sv
// Scheduler <-> core-unit signal bundle; slave is the scheduler, master drives its inputs.
interface core_scheduler_if #(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int PC_BITS           = 8
);
  logic                                       start;
  logic [THREADS_PER_BLOCK-1:0]               thread_enable;
  logic                                       decoded_mem_read_enable;
  logic                                       decoded_mem_write_enable;
  logic                                       decoded_ret;
  logic [1:0]                                 fetcher_state;
  logic [THREADS_PER_BLOCK-1:0][1:0]          lsu_state;
  logic [THREADS_PER_BLOCK-1:0][PC_BITS-1:0]  next_pc;
  logic [2:0]                                 core_state;
  logic [PC_BITS-1:0]                         current_pc;
  logic                                       done;
  logic                                       pc_divergence_err;

  modport master (
    output start, thread_enable, decoded_mem_read_enable, decoded_mem_write_enable,
           decoded_ret, fetcher_state, lsu_state, next_pc,
    input  core_state, current_pc, done, pc_divergence_err
  );

  modport slave (
    input  start, thread_enable, decoded_mem_read_enable, decoded_mem_write_enable,
           decoded_ret, fetcher_state, lsu_state, next_pc,
    output core_state, current_pc, done, pc_divergence_err
  );
endinterface

// File: rtl/core_scheduler.sv
// Per-core control FSM: sequences fetch/decode/memory/execute/update for one shared PC.
// Optional SCHED_DIVERGENCE_CHECK_EN adds a sticky flag for lanes disagreeing on next PC.
module core_scheduler
  import gpu_pkg::*;
#(
  parameter int THREADS_PER_BLOCK = THREADS_DEF,
  parameter int PC_BITS           = PC_BITS_DEF
) (
  input  logic             clk,
  input  logic             reset,
  core_scheduler_if.slave  sif
);

  core_state_e                  state_q, state_d;
  logic [THREADS_PER_BLOCK-1:0] mask_q, mask_d;
  logic [PC_BITS-1:0]           pc_q, pc_d;
  logic                         done_q, done_d;
  logic [PC_BITS-1:0]           sel_pc;
  logic [THREADS_PER_BLOCK-1:0] lane_busy;

  for (genvar i = 0; i < THREADS_PER_BLOCK; i++) begin : g_busy
    assign lane_busy[i] = mask_q[i] &&
                          (sif.lsu_state[i] == LSU_REQUESTING || sif.lsu_state[i] == LSU_WAITING);
  end

  // Descending scan so the lowest-index enabled lane wins.
  always_comb begin
    sel_pc = '0;
    for (int i = THREADS_PER_BLOCK - 1; i >= 0; i--)
      if (mask_q[i]) sel_pc = sif.next_pc[i];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CS_IDLE;
      mask_q  <= '0;
      pc_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    pc_d    = pc_q;
    done_d  = done_q;
    case (state_q)
      CS_IDLE: if (sif.start) begin
        mask_d = sif.thread_enable;
        if (|sif.thread_enable) begin
          pc_d    = '0;
          state_d = CS_FETCH;
        end else begin
          done_d  = 1'b1;
          state_d = CS_DONE;
        end
      end
      CS_FETCH:   if (sif.fetcher_state == FETCHER_FETCHED) state_d = CS_DECODE;
      CS_DECODE:  state_d = CS_REQUEST;
      CS_REQUEST: state_d = CS_WAIT;
      CS_WAIT:    if (!(|lane_busy)) state_d = CS_EXECUTE;
      CS_EXECUTE: state_d = CS_UPDATE;
      CS_UPDATE: begin
        if (sif.decoded_ret) begin
          done_d  = 1'b1;
          state_d = CS_DONE;
        end else begin
          pc_d    = sel_pc;
          state_d = CS_FETCH;
        end
      end
      CS_DONE: if (!sif.start) begin
        done_d  = 1'b0;
        state_d = CS_IDLE;
      end
      default: state_d = CS_IDLE;
    endcase
  end

  assign sif.core_state = state_q;
  assign sif.current_pc = pc_q;
  assign sif.done       = done_q;

`ifdef SCHED_DIVERGENCE_CHECK_EN
  logic                         err_q;
  logic [THREADS_PER_BLOCK-1:0] lane_diverge;

  for (genvar i = 0; i < THREADS_PER_BLOCK; i++) begin : g_div
    assign lane_diverge[i] = mask_q[i] && (sif.next_pc[i] != sel_pc);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else if (state_q == CS_UPDATE && !sif.decoded_ret && |lane_diverge) err_q <= 1'b1;
  end

  assign sif.pc_divergence_err = err_q;
`else
  assign sif.pc_divergence_err = 1'b0;
`endif

endmodule

// File: tb/tb_core_scheduler.sv
// Randomized scoreboard bench for core_scheduler: driver pushes per-instruction
// expectations from a PC/latency model, monitor pops them on observed state changes.
module tb_core_scheduler;
  import gpu_pkg::*;

  localparam int T  = 4;
  localparam int PB = 8;
  typedef logic [T-1:0][PB-1:0] pcv_t;

  localparam int K_PC = 0, K_WAIT = 1, K_LEN = 2, K_DPC = 3, K_ERR = 4;
  typedef struct { int kind; int val; } item_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  item_t q[$];

  int           m_pc  = 0;
  int           m_err = 0;
  logic [T-1:0] blk_mask;

  core_scheduler_if #(.THREADS_PER_BLOCK(T), .PC_BITS(PB)) sif ();
  core_scheduler #(.THREADS_PER_BLOCK(T), .PC_BITS(PB)) dut (.clk(clk), .reset(reset), .sif(sif));

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int kind, input int val);
    item_t it;
    it.kind = kind; it.val = val;
    q.push_back(it);
  endtask

  task automatic expect_item(input int kind, input int act, input string name);
    item_t it;
    if (q.size() == 0) begin
      total++; bad++;
      $display("FAIL %s actual=%0d required=<nothing queued>", name, act);
    end else begin
      it = q.pop_front();
      check({name, "_kind"}, kind, it.kind);
      check(name, act, it.val);
    end
  endtask

  task automatic wait_state(input logic [2:0] s);
    int n = 0;
    do begin @(negedge clk); n++; end while (sif.core_state != s && n < 200);
    if (sif.core_state != s) begin
      bad++; total++;
      $display("FAIL wait_state actual=%0d required=%0d", sif.core_state, s);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  endtask

  // Monitor: compares on state transitions only.
  initial begin : monitor
    logic [2:0] prev = 3'd0;
    logic [2:0] s;
    int cyc = 0, wcnt = 0;
    forever begin
      @(negedge clk);
      s = sif.core_state;
      if (s != prev) begin
        if (s == CS_DECODE) expect_item(K_PC, int'(sif.current_pc), "decode_pc");
        if (prev == CS_WAIT && s == CS_EXECUTE) expect_item(K_WAIT, wcnt, "wait_len");
        if (prev == CS_UPDATE) expect_item(K_LEN, cyc, "instr_len");
        if (s == CS_DONE) begin
          check("done_flag", int'(sif.done), 1);
          expect_item(K_DPC, int'(sif.current_pc), "done_pc");
          expect_item(K_ERR, int'(sif.pc_divergence_err), "div_err");
        end
      end
      if (s == CS_FETCH && prev != CS_FETCH) cyc = 1; else cyc++;
      if (s == CS_WAIT) wcnt = (prev == CS_WAIT) ? wcnt + 1 : 1;
      prev = s;
    end
  end

  task automatic launch(input logic [T-1:0] mask);
    sif.start = 1'b1;
    sif.thread_enable = mask;
    blk_mask = mask;
    m_pc = 0;
  endtask

  // One instruction: d extra fetch cycles, busy for b WAIT edges, bl = busy lane (-1 random).
  task automatic do_instr(input int d, input int b, input int bl, input bit ret, input pcv_t nxt);
    int lm, low, sel, lane;
    lm = int'(blk_mask);
    push(K_PC, m_pc);
    push(K_WAIT, b + 1);
    push(K_LEN, d + b + 6);
    if (ret) begin
      push(K_DPC, m_pc);
      push(K_ERR, m_err);
    end else begin
      low = $clog2(lm & -lm);
      sel = int'(nxt[low]);
`ifdef SCHED_DIVERGENCE_CHECK_EN
      for (int i = 0; i < T; i++)
        if (blk_mask[i] && int'(nxt[i]) != sel) m_err = 1;
`endif
      m_pc = sel;
    end
    wait_state(CS_FETCH);
    sif.start = 1'($urandom_range(0, 1));
    sif.thread_enable = T'($urandom);
    sif.fetcher_state = (d == 0) ? FETCHER_FETCHED : FETCHER_FETCHING;
    repeat (d) @(negedge clk);
    sif.fetcher_state = FETCHER_FETCHED;
    wait_state(CS_DECODE);
    sif.start = 1'b0;
    sif.fetcher_state = FETCHER_IDLE;
    sif.decoded_ret = ret;
    sif.decoded_mem_read_enable  = (b > 0) && ($urandom_range(0, 1) == 1);
    sif.decoded_mem_write_enable = (b > 0) && !sif.decoded_mem_read_enable;
    sif.next_pc = nxt;
    wait_state(CS_REQUEST);
    lane = bl;
    if (lane < 0) do lane = $urandom_range(0, T - 1); while (!blk_mask[lane]);
    for (int i = 0; i < T; i++)
      if (!blk_mask[i]) sif.lsu_state[i] = ($urandom_range(0, 1) == 1) ? LSU_REQUESTING : LSU_WAITING;
      else if (b > 0 && i == lane) sif.lsu_state[i] = ($urandom_range(0, 1) == 1) ? LSU_WAITING : LSU_REQUESTING;
      else sif.lsu_state[i] = ($urandom_range(0, 1) == 1) ? LSU_DONE : LSU_IDLE;
    repeat (b + 1) @(negedge clk);
    for (int i = 0; i < T; i++)
      if (blk_mask[i]) sif.lsu_state[i] = ($urandom_range(0, 1) == 1) ? LSU_DONE : LSU_IDLE;
  endtask

  task automatic finish_block();
    wait_state(CS_DONE);
    @(negedge clk);
    check("done_to_idle_state", int'(sif.core_state), int'(CS_IDLE));
    check("done_to_idle_done", int'(sif.done), 0);
  endtask

  function automatic pcv_t uniform(input int v);
    pcv_t p;
    for (int i = 0; i < T; i++) p[i] = PB'(v);
    return p;
  endfunction

  initial begin : driver
    pcv_t nxt;
    int   n, tgt;
    logic [T-1:0] mk;
    sif.start = 1'b0; sif.thread_enable = '0; sif.decoded_ret = 1'b0;
    sif.decoded_mem_read_enable = 1'b0; sif.decoded_mem_write_enable = 1'b0;
    sif.fetcher_state = FETCHER_IDLE; sif.lsu_state = '0; sif.next_pc = '0;
    #12;
    check("rst_state", int'(sif.core_state), 0);
    check("rst_pc", int'(sif.current_pc), 0);
    check("rst_done", int'(sif.done), 0);
    check("rst_err", int'(sif.pc_divergence_err), 0);
    @(negedge clk); reset = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_no_start", int'(sif.core_state), 0);

    // start with empty mask: straight to DONE, held while start stays high
    push(K_DPC, m_pc); push(K_ERR, m_err);
    sif.start = 1'b1; sif.thread_enable = '0;
    wait_state(CS_DONE);
    @(negedge clk);
    check("done_hold_start", int'(sif.core_state), int'(CS_DONE));
    sif.start = 1'b0;
    @(negedge clk);
    check("zero_mask_idle", int'(sif.core_state), 0);
    check("zero_mask_done_clr", int'(sif.done), 0);

    // ADD then RET, two extra fetch cycles
    launch(4'b1111);
    do_instr(2, 0, -1, 1'b0, uniform(1));
    do_instr(2, 0, -1, 1'b1, uniform(2));
    finish_block();

    // memory op, lane 2 busy, masked-off lane 3 noisy
    launch(4'b0111);
    do_instr(1, 5, 2, 1'b0, uniform(1));
    do_instr(0, 0, -1, 1'b1, uniform(2));
    finish_block();

    // lowest enabled lane is 2
    launch(4'b1100);
    nxt = uniform(9); nxt[0] = 8'd3; nxt[1] = 8'd4;
    do_instr(0, 0, -1, 1'b0, nxt);
    do_instr(0, 0, -1, 1'b1, uniform(0));
    finish_block();

    // lane 1 diverges
    launch(4'b1111);
    nxt = uniform(5); nxt[1] = 8'd7;
    do_instr(1, 0, -1, 1'b0, nxt);
    do_instr(0, 0, -1, 1'b1, uniform(6));
    finish_block();

    // PC wrap past 255
    launch(4'b0010);
    do_instr(0, 0, -1, 1'b0, uniform(255));
    do_instr(0, 0, -1, 1'b0, uniform(0));
    do_instr(0, 0, -1, 1'b1, uniform(1));
    finish_block();

    // randomized blocks
    for (int blk = 0; blk < 12; blk++) begin
      mk = T'($urandom_range(1, (1 << T) - 1));
      launch(mk);
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        tgt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : (m_pc + 1) % 256;
        nxt = uniform(tgt);
        if ($urandom_range(0, 4) == 0) nxt[$urandom_range(0, T - 1)] = PB'($urandom);
        do_instr($urandom_range(0, 3), ($urandom_range(0, 1) == 1) ? $urandom_range(1, 5) : 0,
                 -1, 1'b0, nxt);
      end
      do_instr($urandom_range(0, 2), $urandom_range(0, 2), -1, 1'b1, uniform($urandom_range(0, 255)));
      finish_block();
    end

    // async reset between edges while in WAIT
    launch(4'b1111);
    push(K_PC, 0);
    wait_state(CS_FETCH);
    sif.start = 1'b0;
    sif.fetcher_state = FETCHER_FETCHED;
    wait_state(CS_DECODE);
    sif.fetcher_state = FETCHER_IDLE;
    sif.next_pc = uniform(4);
    wait_state(CS_REQUEST);
    sif.lsu_state[0] = LSU_WAITING;
    @(negedge clk); @(negedge clk);
    check("pre_reset_wait", int'(sif.core_state), int'(CS_WAIT));
    #2 reset = 1'b1;
    #1;
    check("mid_reset_state", int'(sif.core_state), 0);
    check("mid_reset_pc", int'(sif.current_pc), 0);
    check("mid_reset_done", int'(sif.done), 0);
    check("mid_reset_err", int'(sif.pc_divergence_err), 0);
    q.delete();
    m_err = 0;
    sif.lsu_state = '0;
    @(negedge clk); reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("post_reset_idle", int'(sif.core_state), 0);
    end
    check("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
